recip_round_pack: RTL and testbench

Output stage of the floating-point reciprocal unit, directly downstream of the SRT significand calculator. It takes the normalized quotient significand and its guard/round/sticky bits, together with the operand's sign, exponent and class bits carried alongside by the caller's side pipeline. It computes the result exponent, rounds to nearest-even, resolves special cases with flush-to-zero, and packs the IEEE-754 result. A two-stage valid/ready pipeline provides backpressure, and a sticky exception-flag register accumulates flags until cleared.

---
 rtl/recip_pkg.sv | 30 +++
 rtl/recip_rne_round.sv | 26 ++
 rtl/recip_round_pack.sv | 180 ++++++++++++++++++
 tb/tb_recip_round_pack.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recip_pkg.sv
// Shared constants and types for the reciprocal output stage.
package recip_pkg;

  localparam int FLG_INVALID = 4;
  localparam int FLG_DIVZ    = 3;
  localparam int FLG_OVF     = 2;
  localparam int FLG_UDF     = 1;
  localparam int FLG_INX     = 0;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } op_class_t;

  function automatic int bias_of(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Magnitude bits of +inf: exponent all ones, fraction zero.
  function automatic logic [63:0] inf_bits(input int ew, input int sw);
    return ((64'd1 << ew) - 64'd1) << sw;
  endfunction

  function automatic logic [63:0] qnan_bits(input int ew, input int sw);
    return inf_bits(ew, sw) | (64'd1 << (sw - 1));
  endfunction

endpackage

// File: rtl/recip_rne_round.sv
// Combinational round-to-nearest-even incrementer on the quotient fraction.
module recip_rne_round
  import recip_pkg::*;
#(
  parameter int sig_width = 23
) (
  input  logic [sig_width:0]   q,
  input  logic                 g,
  input  logic                 r,
  input  logic                 s,
  output logic [sig_width-1:0] frac,
  output logic                 carry,
  output logic                 inexact
);

  logic             inc;
  logic [sig_width:0] sum;

  assign inc     = g & (r | s | q[0]);
  assign sum     = q + {{sig_width{1'b0}}, inc};
  assign frac    = sum[sig_width-1:0];
  // The hidden bit is always 1, so it dropping to 0 marks a carry out of the fraction.
  assign carry   = q[sig_width] & ~sum[sig_width];
  assign inexact = g | r | s;

endmodule

// File: rtl/recip_round_pack.sv
// Reciprocal exponent/round/special-case/pack stage; 2-cycle latency, 1 beat/cycle.
// Two valid/ready register stages; a stalled stage holds, in_ready = ~vA | ready_B.
module recip_round_pack
  import recip_pkg::*;
#(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           sign_in,
  input  logic [exp_width-1:0]           exp_in,
  input  logic                           frac_zero_in,
  input  logic                           is_zero_in,
  input  logic                           is_inf_in,
  input  logic                           is_nan_in,
  input  logic                           snan_in,
  input  logic [sig_width:0]             quotient,
  input  logic                           guard_bit,
  input  logic                           round_bit,
  input  logic                           sticky_bit,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [exp_width+sig_width:0]   result,
  output logic [4:0]                     flags,
  output logic [4:0]                     flags_sticky,
  input  logic                           flag_clear
);

  localparam int RW = exp_width + sig_width + 1;
  localparam int MW = RW - 1;
  localparam int EW = exp_width + 2;
  localparam logic [EW-1:0] TWO_BIAS = EW'(2 * bias_of(exp_width));
  localparam logic [EW-1:0] EXP_MAX  = EW'((1 << exp_width) - 1);
  localparam logic [RW-1:0] QNAN     = RW'(qnan_bits(exp_width, sig_width));
  localparam logic [MW-1:0] INF_MAG  = MW'(inf_bits(exp_width, sig_width));

  // Stage A state
  logic                 va;
  logic                 sign_a;
  op_class_t            cls_a;
  logic                 snan_a;
  logic [EW-1:0]        er_a;
  logic [sig_width-1:0] frac_a;
  logic                 carry_a;
  logic                 inx_a;

  // Stage B state
  logic                 vb;
  logic [RW-1:0]        res_b;
  logic [4:0]           flg_b;

  logic                 ready_b;
  op_class_t            cls_in;
  logic [EW-1:0]        er_in;
  logic [sig_width-1:0] frac_r;
  logic                 carry_r;
  logic                 inx_r;

  logic [EW-1:0]        er_post;
  logic                 udf;
  logic                 ovf;
  logic [RW-1:0]        res_n;
  logic [4:0]           flg_n;

  assign ready_b  = ~vb | out_ready;
  assign in_ready = ~reset & (~va | ready_b);

  always_comb begin
    cls_in = CLS_NORM;
    if (is_nan_in)       cls_in = CLS_NAN;
    else if (is_inf_in)  cls_in = CLS_INF;
    else if (is_zero_in) cls_in = CLS_ZERO;
  end

  // Exact powers of two invert to an exact power of two one exponent higher.
  assign er_in = frac_zero_in ? (TWO_BIAS - EW'(exp_in))
                              : (TWO_BIAS - EW'(exp_in) - EW'(1));

  recip_rne_round #(.sig_width(sig_width)) u_round (
    .q       (quotient),
    .g       (guard_bit),
    .r       (round_bit),
    .s       (sticky_bit),
    .frac    (frac_r),
    .carry   (carry_r),
    .inexact (inx_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      va      <= 1'b0;
      sign_a  <= 1'b0;
      cls_a   <= CLS_NORM;
      snan_a  <= 1'b0;
      er_a    <= '0;
      frac_a  <= '0;
      carry_a <= 1'b0;
      inx_a   <= 1'b0;
    end else if (in_ready) begin
      va <= in_valid;
      if (in_valid) begin
        sign_a  <= sign_in;
        cls_a   <= cls_in;
        snan_a  <= snan_in;
        er_a    <= er_in;
        frac_a  <= frac_zero_in ? '0 : frac_r;
        carry_a <= ~frac_zero_in & carry_r;
        inx_a   <= ~frac_zero_in & inx_r;
      end
    end
  end

  always_comb begin
    er_post = er_a + EW'(carry_a);
    // Underflow is judged on the pre-round exponent; overflow on the post-round one.
    udf     = er_a[EW-1] | ~|er_a;
    ovf     = ~er_post[EW-1] & (er_post >= EXP_MAX);
    res_n   = {sign_a, er_post[exp_width-1:0], frac_a};
    flg_n   = '0;
    case (cls_a)
      CLS_NAN: begin
        res_n              = QNAN;
        flg_n[FLG_INVALID] = snan_a;
      end
      CLS_INF: begin
        res_n = {sign_a, {MW{1'b0}}};
      end
      CLS_ZERO: begin
        res_n           = {sign_a, INF_MAG};
        flg_n[FLG_DIVZ] = 1'b1;
      end
      default: begin
        if (udf) begin
          res_n          = {sign_a, {MW{1'b0}}};
          flg_n[FLG_UDF] = 1'b1;
          flg_n[FLG_INX] = 1'b1;
        end else if (ovf) begin
          res_n          = {sign_a, INF_MAG};
          flg_n[FLG_OVF] = 1'b1;
          flg_n[FLG_INX] = 1'b1;
        end else begin
          flg_n[FLG_INX] = inx_a;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vb    <= 1'b0;
      res_b <= '0;
      flg_b <= '0;
    end else if (ready_b) begin
      vb <= va;
      if (va) begin
        res_b <= res_n;
        flg_b <= flg_n;
      end
    end
  end

  // A clear coinciding with a delivery keeps that beat's flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_sticky <= '0;
    end else if (vb && out_ready) begin
      flags_sticky <= flag_clear ? flg_b : (flags_sticky | flg_b);
    end else if (flag_clear) begin
      flags_sticky <= '0;
    end
  end

  assign out_valid = vb;
  assign result    = res_b;
  assign flags     = flg_b;

endmodule

// File: tb/tb_recip_round_pack.sv
// Randomized and directed checks of recip_round_pack against an arithmetic reference model.
module tb_recip_round_pack;

  typedef struct {
    logic       sgn;
    logic [7:0] e;
    logic       fz;
    logic       z;
    logic       inf;
    logic       nan;
    logic       sn;
    logic [23:0] q;
    logic       g;
    logic       r;
    logic       s;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic        frac_zero_in;
  logic        is_zero_in, is_inf_in, is_nan_in, snan_in;
  logic [23:0] quotient;
  logic        guard_bit, round_bit, sticky_bit;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  flags;
  logic [4:0]  flags_sticky;
  logic        flag_clear;

  int vectors = 0;
  int miscompares = 0;
  logic [36:0] exp_q[$];
  logic [4:0]  sticky_m = '0;

  recip_round_pack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .frac_zero_in(frac_zero_in),
    .is_zero_in(is_zero_in), .is_inf_in(is_inf_in), .is_nan_in(is_nan_in),
    .snan_in(snan_in), .quotient(quotient), .guard_bit(guard_bit),
    .round_bit(round_bit), .sticky_bit(sticky_bit), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags),
    .flags_sticky(flags_sticky), .flag_clear(flag_clear)
  );

  always #5 clk = ~clk;

  // Reference: IEEE single reciprocal result {result, flags} from the operand description.
  function automatic logic [36:0] model(input beat_t b);
    int er;
    int fr;
    logic inx;
    logic [7:0] e8;
    logic [22:0] f23;
    if (b.nan) return {32'h7FC00000, b.sn, 4'b0000};
    if (b.inf) return {b.sgn, 31'd0, 5'b00000};
    if (b.z)   return {b.sgn, 8'hFF, 23'd0, 5'b01000};
    if (b.fz) begin
      er = 254 - int'(b.e);
      fr = 0;
      inx = 1'b0;
    end else begin
      er = 253 - int'(b.e);
      inx = b.g | b.r | b.s;
      fr = int'(b.q[22:0]);
      if (b.g && (b.r || b.s || b.q[0])) fr = fr + 1;
    end
    if (er <= 0) return {b.sgn, 31'd0, 5'b00011};
    if (fr == (1 << 23)) begin
      fr = 0;
      er = er + 1;
    end
    if (er >= 255) return {b.sgn, 8'hFF, 23'd0, 5'b00101};
    e8 = 8'(er);
    f23 = 23'(fr);
    return {b.sgn, e8, f23, 4'b0000, inx};
  endfunction

  function automatic beat_t pins();
    beat_t b;
    b.sgn = sign_in; b.e = exp_in; b.fz = frac_zero_in; b.z = is_zero_in;
    b.inf = is_inf_in; b.nan = is_nan_in; b.sn = snan_in; b.q = quotient;
    b.g = guard_bit; b.r = round_bit; b.s = sticky_bit;
    return b;
  endfunction

  function automatic beat_t mk(input logic sg, input logic [7:0] e, input logic fz,
                               input logic [1:0] cls, input logic sn,
                               input logic [23:0] q, input logic g, input logic r,
                               input logic s);
    beat_t b;
    b.sgn = sg; b.e = e; b.fz = fz; b.z = (cls == 2'd1); b.inf = (cls == 2'd2);
    b.nan = (cls == 2'd3); b.sn = sn & (cls == 2'd3); b.q = q; b.g = g; b.r = r; b.s = s;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    logic [7:0] edges [9];
    logic [7:0] e;
    logic [1:0] cls;
    int k;
    edges = '{8'd1, 8'd2, 8'd125, 8'd126, 8'd127, 8'd128, 8'd252, 8'd253, 8'd254};
    k = $urandom_range(0, 9);
    cls = (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : (k == 2) ? 2'd3 : 2'd0;
    if ($urandom_range(0, 2) == 0) e = edges[$urandom_range(0, 8)];
    else e = 8'($urandom_range(1, 254));
    return mk(1'($urandom), e, ($urandom_range(0, 3) == 0), cls, 1'($urandom),
              {1'b1, 23'($urandom)}, 1'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  task automatic drive(input beat_t b);
    sign_in = b.sgn; exp_in = b.e; frac_zero_in = b.fz; is_zero_in = b.z;
    is_inf_in = b.inf; is_nan_in = b.nan; snan_in = b.sn; quotient = b.q;
    guard_bit = b.g; round_bit = b.r; sticky_bit = b.s;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Compare process: every meaningful cycle, outputs against the model queue and sticky model.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      sticky_m = '0;
    end else begin
      vectors++;
      if (flags_sticky !== sticky_m) begin
        miscompares++;
        $display("FAIL sticky: got %b, required %b", flags_sticky, sticky_m);
      end
      if (out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_out: result %h with nothing expected", result);
        end else begin
          if ({result, flags} !== exp_q[0]) begin
            miscompares++;
            $display("FAIL stream: got %h/%b, required %h/%b",
                     result, flags, exp_q[0][36:5], exp_q[0][4:0]);
          end
          if (out_ready) begin
            sticky_m = flag_clear ? exp_q[0][4:0] : (sticky_m | exp_q[0][4:0]);
            void'(exp_q.pop_front());
          end
        end
      end
      if (!(out_valid && out_ready) && flag_clear) sticky_m = '0;
      if (in_valid && in_ready) exp_q.push_back(model(pins()));
    end
  end

  task automatic one_beat(input string nm, input beat_t b, input logic [31:0] er,
                          input logic [4:0] ef);
    int n;
    @(posedge clk); #1;
    drive(b);
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd2);
    chk({nm, "_result"}, 64'(result), 64'(er));
    chk({nm, "_flags"}, 64'(flags), 64'(ef));
  endtask

  beat_t bp [4];

  initial begin
    int acc, k, n;
    logic fire;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flag_clear = 1'b0;
    drive(mk(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_sticky", 64'(flags_sticky), 64'd0);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    one_beat("half", mk(1'b0, 8'd128, 1'b1, 2'd0, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0),
             32'h3F000000, 5'b00000);
    one_beat("third", mk(1'b0, 8'd128, 1'b0, 2'd0, 1'b0, 24'hAAAAAA, 1'b1, 1'b0, 1'b1),
             32'h3EAAAAAB, 5'b00001);
    @(posedge clk); #1;
    flag_clear = 1'b1;
    @(posedge clk); #1;
    flag_clear = 1'b0;
    one_beat("zero", mk(1'b1, 8'd0, 1'b0, 2'd1, 1'b0, 24'h800000, 1'b1, 1'b1, 1'b1),
             32'hFF800000, 5'b01000);
    one_beat("inf", mk(1'b0, 8'hFF, 1'b1, 2'd2, 1'b0, 24'hFFFFFF, 1'b1, 1'b0, 1'b0),
             32'h00000000, 5'b00000);
    one_beat("snan", mk(1'b1, 8'hFF, 1'b0, 2'd3, 1'b1, 24'hC00001, 1'b1, 1'b1, 1'b0),
             32'h7FC00000, 5'b10000);
    @(posedge clk); #1;
    chk("sticky_specials", 64'(flags_sticky), 64'b11000);
    flag_clear = 1'b1;
    @(posedge clk); #1;
    flag_clear = 1'b0;
    chk("sticky_cleared", 64'(flags_sticky), 64'd0);

    one_beat("underflow", mk(1'b0, 8'd254, 1'b0, 2'd0, 1'b0, 24'h9ABCDE, 1'b0, 1'b0, 1'b0),
             32'h00000000, 5'b00011);
    one_beat("carry", mk(1'b0, 8'd100, 1'b0, 2'd0, 1'b0, 24'hFFFFFF, 1'b1, 1'b0, 1'b0),
             32'h4D000000, 5'b00001);
    @(posedge clk); #1;

    // Backpressure: consumer stalled while four beats are offered back to back.
    for (int i = 0; i < 4; i++) bp[i] = rand_beat();
    out_ready = 1'b0;
    acc = 0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      drive(bp[(k < 4) ? k : 3]);
      in_valid = 1'b1;
      @(negedge clk);
      fire = in_ready;
      @(posedge clk); #1;
      if (fire) begin
        acc++;
        k++;
      end
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    n = 0;
    while (k < 4 && n < 50) begin
      drive(bp[k]);
      in_valid = 1'b1;
      @(negedge clk);
      fire = in_ready;
      @(posedge clk); #1;
      if (fire) k++;
      n++;
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Randomized traffic with random stalls and clears.
    for (int c = 0; c < 800; c++) begin
      drive(rand_beat());
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flag_clear = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    flag_clear = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(mk(1'b0, 8'd0, 1'b0, 2'd1, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("full_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("in_ready_mid_reset", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_sticky", 64'(flags_sticky), 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    one_beat("post_reset", mk(1'b1, 8'd128, 1'b1, 2'd0, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0),
             32'hBF000000, 5'b00000);
    @(posedge clk); #1;
    chk("post_reset_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
